// File: rtl/red_pitaya_boxcar_pkg.sv
// Shared definitions for the triggered boxcar integrator: FSM encoding and
// register map of the DSP bus slave.
package red_pitaya_boxcar_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DELAY     = 2'd1,
    ST_INTEGRATE = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  localparam logic [15:0] ADDR_CTRL  = 16'h0100;
  localparam logic [15:0] ADDR_DELAY = 16'h0104;
  localparam logic [15:0] ADDR_WIDTH = 16'h0108;
  localparam logic [15:0] ADDR_SHIFT = 16'h010C;
  localparam logic [15:0] ADDR_DATO  = 16'h0110;
  localparam logic [15:0] ADDR_NACC  = 16'h0114;
  localparam logic [15:0] ADDR_NMISS = 16'h0118;
  localparam logic [15:0] ADDR_RAW   = 16'h011C;

endpackage

// File: rtl/red_pitaya_saturate.sv
// Combinational signed clamp from IN bits down to OUT bits.
module red_pitaya_saturate #(
  parameter int IN  = 32,
  parameter int OUT = 14
) (
  input  logic signed [IN-1:0]  in_i,
  output logic signed [OUT-1:0] out_o
);

  localparam logic signed [IN-1:0] MAXV = {{(IN-OUT+1){1'b0}}, {(OUT-1){1'b1}}};
  localparam logic signed [IN-1:0] MINV = {{(IN-OUT+1){1'b1}}, {(OUT-1){1'b0}}};

  // Clamp to the representable OUT-bit signed range
  always_comb begin
    out_o = in_i[OUT-1:0];
    if (in_i > MAXV)
      out_o = MAXV[OUT-1:0];
    else if (in_i < MINV)
      out_o = MINV[OUT-1:0];
  end

endmodule

// File: rtl/red_pitaya_boxcar_block.sv
// Triggered boxcar integrator: on an accepted trigger wait `delay` cycles,
// sum dat_i over `width` samples, scale by 2^-shift, saturate and hold.
module red_pitaya_boxcar_block
  import red_pitaya_boxcar_pkg::*;
#(
  parameter int ACCBITS   = 32,
  parameter int WIDTHBITS = 16
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [13:0] dat_i,
  input  logic        trig_i,
  output logic [13:0] dat_o,
  output logic        valid_o,
  output logic        busy_o,
  output logic        gate_o,
  input  logic [15:0] addr,
  input  logic        wen,
  input  logic        ren,
  output logic        ack,
  output logic [31:0] rdata,
  input  logic [31:0] wdata
);

  state_e state_q, state_d;

  logic [31:0]                delay_q, delay_d;
  logic [WIDTHBITS-1:0]       width_q, width_d;
  logic [4:0]                 shift_q, shift_d;
  logic [31:0]                dly_cnt_q, dly_cnt_d;
  logic [WIDTHBITS-1:0]       wcnt_q, wcnt_d;
  logic [4:0]                 shift_w_q, shift_w_d;
  logic signed [ACCBITS-1:0]  acc_q, acc_d;
  logic [13:0]                dat_o_q, dat_o_d;
  logic                       valid_q, valid_d;
  logic [31:0]                raw_q, raw_d;
  logic [31:0]                nacc_q, nacc_d;
  logic [31:0]                nmiss_q, nmiss_d;
  logic                       ack_q, ack_d;
  logic [31:0]                rdata_q, rdata_d;

  logic                       trig;
  logic signed [ACCBITS-1:0]  dat_ext;
  logic signed [ACCBITS-1:0]  acc_sum;
  logic signed [ACCBITS-1:0]  acc_shift;
  logic signed [13:0]         sat_out;

  assign trig      = trig_i | (wen && (addr == ADDR_CTRL));
  assign dat_ext   = {{(ACCBITS-14){dat_i[13]}}, dat_i};
  assign acc_sum   = acc_q + dat_ext;
  assign acc_shift = acc_sum >>> shift_w_q;

  red_pitaya_saturate #(
    .IN  (ACCBITS),
    .OUT (14)
  ) u_sat (
    .in_i  (acc_shift),
    .out_o (sat_out)
  );

  // FSM next-state: IDLE -> (DELAY) -> INTEGRATE -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (trig) state_d = (delay_q == '0) ? ST_INTEGRATE : ST_DELAY;
      ST_DELAY:     if (dly_cnt_q == '0) state_d = ST_INTEGRATE;
      ST_INTEGRATE: if (wcnt_q == '0) state_d = ST_DONE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Datapath, counters, configuration and bus slave.
  // The result is computed from acc_sum on the last INTEGRATE cycle so that
  // dat_o and valid_o change together as the FSM enters DONE.
  always_comb begin
    delay_d   = delay_q;
    width_d   = width_q;
    shift_d   = shift_q;
    dly_cnt_d = dly_cnt_q;
    wcnt_d    = wcnt_q;
    shift_w_d = shift_w_q;
    acc_d     = acc_q;
    dat_o_d   = dat_o_q;
    valid_d   = 1'b0;
    raw_d     = raw_q;
    nacc_d    = nacc_q;
    nmiss_d   = nmiss_q;
    ack_d     = wen | ren;
    rdata_d   = '0;

    if (trig) begin
      if (state_q == ST_IDLE) begin
        dly_cnt_d = delay_q - 32'd1;
        wcnt_d    = (width_q == '0) ? '0 : width_q - WIDTHBITS'(1);
        shift_w_d = shift_q;
        acc_d     = '0;
        nacc_d    = nacc_q + 32'd1;
      end else begin
        nmiss_d   = nmiss_q + 32'd1;
      end
    end

    if (state_q == ST_DELAY && dly_cnt_q != '0)
      dly_cnt_d = dly_cnt_q - 32'd1;

    if (state_q == ST_INTEGRATE) begin
      acc_d = acc_sum;
      if (wcnt_q != '0) begin
        wcnt_d = wcnt_q - WIDTHBITS'(1);
      end else begin
        dat_o_d = sat_out;
        valid_d = 1'b1;
        raw_d   = 32'(acc_sum);
      end
    end

    if (wen) begin
      case (addr)
        ADDR_DELAY: delay_d = wdata;
        ADDR_WIDTH: width_d = wdata[WIDTHBITS-1:0];
        ADDR_SHIFT: shift_d = wdata[4:0];
        default:    ;
      endcase
    end

    if (ren) begin
      case (addr)
        ADDR_CTRL:  rdata_d = {29'b0, (state_q != ST_IDLE), state_q};
        ADDR_DELAY: rdata_d = delay_q;
        ADDR_WIDTH: rdata_d = 32'(width_q);
        ADDR_SHIFT: rdata_d = {27'b0, shift_q};
        ADDR_DATO:  rdata_d = {{18{dat_o_q[13]}}, dat_o_q};
        ADDR_NACC:  rdata_d = nacc_q;
        ADDR_NMISS: rdata_d = nmiss_q;
        ADDR_RAW:   rdata_d = raw_q;
        default:    rdata_d = '0;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      delay_q   <= '0;
      width_q   <= WIDTHBITS'(1);
      shift_q   <= '0;
      dly_cnt_q <= '0;
      wcnt_q    <= '0;
      shift_w_q <= '0;
      acc_q     <= '0;
      dat_o_q   <= '0;
      valid_q   <= 1'b0;
      raw_q     <= '0;
      nacc_q    <= '0;
      nmiss_q   <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      delay_q   <= delay_d;
      width_q   <= width_d;
      shift_q   <= shift_d;
      dly_cnt_q <= dly_cnt_d;
      wcnt_q    <= wcnt_d;
      shift_w_q <= shift_w_d;
      acc_q     <= acc_d;
      dat_o_q   <= dat_o_d;
      valid_q   <= valid_d;
      raw_q     <= raw_d;
      nacc_q    <= nacc_d;
      nmiss_q   <= nmiss_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign dat_o   = dat_o_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q != ST_IDLE);
  assign gate_o  = (state_q == ST_INTEGRATE);
  assign ack     = ack_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_red_pitaya_boxcar_block.sv
// Bench for the boxcar integrator: directed scenarios plus randomized
// acquisitions compared against a window-sum reference model.
module tb_red_pitaya_boxcar_block;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [13:0] dat_i;
  logic        trig_i;
  logic [13:0] dat_o;
  logic        valid_o;
  logic        busy_o;
  logic        gate_o;
  logic [15:0] addr;
  logic        wen;
  logic        ren;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;
  int acc_exp = 0;
  int miss_exp = 0;

  red_pitaya_boxcar_block #(
    .ACCBITS   (32),
    .WIDTHBITS (16)
  ) dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .dat_i   (dat_i),
    .trig_i  (trig_i),
    .dat_o   (dat_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .gate_o  (gate_o),
    .addr    (addr),
    .wen     (wen),
    .ren     (ren),
    .ack     (ack),
    .rdata   (rdata),
    .wdata   (wdata)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic longint clamp14(input longint x);
    if (x > 8191)  return 8191;
    if (x < -8192) return -8192;
    return x;
  endfunction

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    addr = a; wdata = d; wen = 1'b1;
    cycle();
    wen = 1'b0;
    chk("wr_ack", {31'b0, ack}, 32'd1);
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
    addr = a; ren = 1'b1;
    cycle();
    ren = 1'b0;
    chk("rd_ack", {31'b0, ack}, 32'd1);
    d = rdata;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_dat_o"}, {18'b0, dat_o}, 32'd0);
    chk({tag, "_valid"}, {31'b0, valid_o}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy_o}, 32'd0);
    chk({tag, "_gate"},  {31'b0, gate_o}, 32'd0);
    chk({tag, "_ack"},   {31'b0, ack}, 32'd0);
  endtask

  task automatic do_reset();
    trig_i = 1'b0; wen = 1'b0; ren = 1'b0; dat_i = '0;
    rstn_i = 1'b0;
    #1;
    check_quiet("rst");
    cycle(); cycle();
    rstn_i = 1'b1;
    cycle();
    acc_exp = 0;
    miss_exp = 0;
  endtask

  // One acquisition. Offset k is measured from the trigger cycle (k = 0).
  // tmode: 0 = trig_i, 1 = bus write to 0x100, 2 = both together.
  task automatic run_acq(input int d, input int w, input int s, input bit rnd,
                         input int cval, input int tmode, input bit miss, input bit abort);
    int weff;
    int gstart;
    int gend;
    int vcyc;
    longint sum;
    longint res;
    logic [13:0] v;
    logic [31:0] rd;
    weff   = (w == 0) ? 1 : w;
    gstart = d + 1;
    gend   = d + weff;
    vcyc   = d + weff + 1;
    sum    = 0;
    bus_wr(16'h0104, 32'(d));
    bus_wr(16'h0108, 32'(w));
    bus_wr(16'h010C, 32'(s));
    for (int k = 0; k <= vcyc + 1; k++) begin
      if (k > 0) begin
        chk("gate",  {31'b0, gate_o},  {31'b0, (k >= gstart && k <= gend)});
        chk("busy",  {31'b0, busy_o},  {31'b0, (k <= vcyc)});
        chk("valid", {31'b0, valid_o}, {31'b0, (k == vcyc)});
        if (k >= vcyc) begin
          res = clamp14(sum >>> s);
          chk("dat_o", {{18{dat_o[13]}}, dat_o}, 32'(res));
        end
      end
      if (abort && k == gstart) begin
        trig_i = 1'b0; wen = 1'b0;
        rstn_i = 1'b0;
        #1;
        check_quiet("abort");
        cycle(); cycle();
        rstn_i = 1'b1;
        acc_exp = 0;
        miss_exp = 0;
        for (int j = 0; j < 12; j++) begin
          cycle();
          chk("abort_valid", {31'b0, valid_o}, 32'd0);
          chk("abort_busy",  {31'b0, busy_o},  32'd0);
        end
        return;
      end
      v = rnd ? 14'($urandom) : 14'(cval);
      dat_i = v;
      if (k >= gstart && k <= gend) sum += $signed(v);
      if (k == 0) begin
        trig_i = (tmode != 1);
        wen    = (tmode != 0);
        addr   = 16'h0100;
        wdata  = $urandom;
        acc_exp++;
      end else begin
        wen    = 1'b0;
        trig_i = miss && (k == gstart || k == vcyc);
        if (miss && (k == gstart || k == vcyc)) miss_exp++;
      end
      cycle();
    end
    trig_i = 1'b0;
    res = clamp14(sum >>> s);
    bus_rd(16'h011C, rd);
    chk("raw_acc", rd, 32'(sum));
    bus_rd(16'h0110, rd);
    chk("rd_dat_o", rd, 32'(res));
  endtask

  logic [31:0] rd;
  logic [31:0] rv;

  initial begin
    addr = '0; wdata = '0;
    do_reset();

    // Reset defaults and register readback
    bus_rd(16'h0108, rd); chk("width_rst", rd, 32'd1);
    bus_rd(16'h0104, rd); chk("delay_rst", rd, 32'd0);
    bus_rd(16'h010C, rd); chk("shift_rst", rd, 32'd0);
    bus_rd(16'h0100, rd); chk("status_idle", rd, 32'd0);
    bus_rd(16'h0200, rd); chk("unmapped", rd, 32'd0);
    rv = $urandom;
    bus_wr(16'h0104, rv);
    bus_rd(16'h0104, rd); chk("delay_rw", rd, rv);

    // Nominal window, zero delay with width 0, saturation both ways
    run_acq(3, 4, 2, 1'b0, 100, 0, 1'b0, 1'b0);
    run_acq(0, 0, 0, 1'b0, -8192, 0, 1'b0, 1'b0);
    run_acq(0, 4, 0, 1'b0, 5000, 1, 1'b0, 1'b0);
    run_acq(0, 4, 0, 1'b0, -5000, 2, 1'b0, 1'b0);

    // Randomized acquisitions
    for (int i = 0; i < 10; i++)
      run_acq(int'($urandom_range(0, 5)), int'($urandom_range(0, 20)),
              int'($urandom_range(0, 7)), 1'b1, 0,
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);
    bus_rd(16'h0114, rd); chk("nacc_rand", rd, 32'(acc_exp));
    bus_rd(16'h0118, rd); chk("nmiss_rand", rd, 32'(miss_exp));

    // Triggers during INTEGRATE and DONE are counted as missed
    do_reset();
    run_acq(3, 4, 2, 1'b0, 100, 0, 1'b1, 1'b0);
    bus_rd(16'h0114, rd); chk("nacc_miss", rd, 32'd1);
    bus_rd(16'h0118, rd); chk("nmiss_miss", rd, 32'd2);

    // Reset during INTEGRATE, then a clean repeat
    run_acq(3, 4, 2, 1'b0, 100, 0, 1'b0, 1'b1);
    run_acq(3, 4, 2, 1'b0, 100, 0, 1'b0, 1'b0);
    bus_rd(16'h0114, rd); chk("nacc_after_abort", rd, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
